// File: rtl/icetap_scan_bank.sv
// ---------------------------------------------------------------------------
// icetap_scan_bank
//
// Purpose:
//   A bank of NR_REGS independent scan registers sharing one serial shift
//   path. A capture loads the shared shift register from the selected
//   parallel input slice, shift_ena moves it one bit per cycle (MSB out,
//   shift_in into the LSB), and update commits the shift register into the
//   held par_out slice of the register chosen at capture time.
//
// Ports:
//   scan_clk   in   single clock for all logic
//   scan_reset in   asynchronous active-high reset
//   sel        in   register select, sampled only on capture
//   capture    in   load shift register from par_in slice[sel]
//   shift_ena  in   shift one bit per cycle
//   shift_in   in   serial data in
//   shift_out  out  serial data out (shift register MSB)
//   update     in   commit shift register to par_out slice[sel_q]
//   par_in     in   capture values, register k at [k*REG_BITS +: REG_BITS]
//   par_out    out  held register contents, same slicing as par_in
//   upd_pulse  out  one-cycle strobe per register on a committed update
//   len_err    out  sticky flag for an update with the wrong shift count
//   busy       out  high whenever the FSM is not IDLE
//
// Configuration:
//   ICETAP_SCAN_LEN_CHECK_EN  when defined, an update only commits if
//   exactly REG_BITS shifts happened since capture; any other count skips
//   the write and sets len_err. When undefined every update commits and
//   len_err is tied low.
// ---------------------------------------------------------------------------
module icetap_scan_bank #(
    parameter int NR_REGS  = 4,
    parameter int REG_BITS = 48,
    localparam int SEL_BITS = (NR_REGS > 1) ? $clog2(NR_REGS) : 1,
    localparam int CNT_BITS = $clog2(REG_BITS + 1)
) (
    input  logic                         scan_clk,
    input  logic                         scan_reset,
    input  logic [SEL_BITS-1:0]          sel,
    input  logic                         capture,
    input  logic                         shift_ena,
    input  logic                         shift_in,
    output logic                         shift_out,
    input  logic                         update,
    input  logic [NR_REGS*REG_BITS-1:0]  par_in,
    output logic [NR_REGS*REG_BITS-1:0]  par_out,
    output logic [NR_REGS-1:0]           upd_pulse,
    output logic                         len_err,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFTING} state_t;

    // The counter carries one spare bit so the saturation value REG_BITS+1
    // fits even when REG_BITS+1 is a power of two.
    localparam logic [CNT_BITS:0] CNT_SAT = (CNT_BITS+1)'(REG_BITS + 1);

    state_t                state;
    state_t                state_next;
    logic [REG_BITS-1:0]   shreg;
    logic [REG_BITS-1:0]   cap_val;
    logic [CNT_BITS:0]     bit_cnt;
    logic [SEL_BITS-1:0]   sel_q;
    logic                  sel_vld;
    logic                  sel_ok;
    logic                  active;
    logic                  commit_ok;

    assign active    = (state != IDLE);
    assign busy      = active;
    assign shift_out = shreg[REG_BITS-1];
    assign sel_ok    = (int'(sel) < NR_REGS);

    // Slice selected by sel; an out-of-range select yields all zeros.
    always_comb begin
        cap_val = '0;
        for (int k = 0; k < NR_REGS; k++) begin
            if (int'(sel) == k) begin
                cap_val = par_in[k*REG_BITS +: REG_BITS];
            end
        end
    end

    // State register.
    always_ff @(posedge scan_clk or posedge scan_reset) begin
        if (scan_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. An asserted update owns the cycle even in IDLE, where it
    // does nothing, so a simultaneous capture is dropped in that cycle.
    always_comb begin
        state_next = state;
        if (update) begin
            if (active) begin
                state_next = IDLE;
            end
        end else if (capture) begin
            state_next = LOADED;
        end else if (shift_ena && active) begin
            state_next = SHIFTING;
        end
    end

    // Shift path, select latch, held registers and update strobe.
    always_ff @(posedge scan_clk or posedge scan_reset) begin
        if (scan_reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            sel_q     <= '0;
            sel_vld   <= 1'b0;
            par_out   <= '0;
            upd_pulse <= '0;
        end else begin
            upd_pulse <= '0;
            if (update) begin
                if (active && commit_ok && sel_vld) begin
                    for (int k = 0; k < NR_REGS; k++) begin
                        if (int'(sel_q) == k) begin
                            par_out[k*REG_BITS +: REG_BITS] <= shreg;
                            upd_pulse[k]                    <= 1'b1;
                        end
                    end
                end
            end else if (capture) begin
                shreg   <= cap_val;
                sel_q   <= sel_ok ? sel : '0;
                sel_vld <= sel_ok;
                bit_cnt <= '0;
            end else if (shift_ena && active) begin
                shreg <= {shreg[REG_BITS-2:0], shift_in};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ICETAP_SCAN_LEN_CHECK_EN
    assign commit_ok = (bit_cnt == (CNT_BITS+1)'(REG_BITS));

    // Sticky length error; only reset clears it.
    always_ff @(posedge scan_clk or posedge scan_reset) begin
        if (scan_reset) begin
            len_err <= 1'b0;
        end else if (update && active && !commit_ok) begin
            len_err <= 1'b1;
        end
    end
`else
    assign commit_ok = 1'b1;
    assign len_err   = 1'b0;
`endif

endmodule
